// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory initiator.
// Size codes, memory strobe bit positions, FSM states, request latch.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int MEM_SIG_WR = 0;
  localparam int MEM_SIG_RD = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        we;
    logic        uns;
    logic        err;
  } req_t;

endpackage

// File: rtl/mem_access_align.sv
// Sub-word store merge and load extract/extend for the data port.
// Purely combinational; the memory is little-endian.
module mem_access_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] cap,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  always_comb begin
    wword = wdata;
    rdata = cap;
    unique case (size)
      SZ_BYTE: begin
        wword = {cap[31:8], wdata[7:0]};
        rdata = {{24{~uns & cap[7]}}, cap[7:0]};
      end
      SZ_HALF: begin
        wword = {cap[31:16], wdata[15:0]};
        rdata = {{16{~uns & cap[15]}}, cap[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: one load/store at a time, RMW for sub-word stores.
// Memory strobes come only from registered state, never from req_* inputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [2:0]  mem_signal_o,
  input  logic [31:0] mem_data_i
);

  state_e      state_q, state_d;
  req_t        req_q;
  logic [31:0] cap_q;
  logic [31:0] wword;
  logic [31:0] rdata;
  logic        bad_req;

  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign bad_req = (req_size_i == 2'd3) ||
                   (({1'b0, req_addr_i} + 33'd3) >= 33'(MEM_BYTES));

  mem_access_align u_align (
    .cap   (cap_q),
    .wdata (req_q.wdata),
    .size  (req_q.size),
    .uns   (req_q.uns),
    .wword (wword),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid_i) begin
        req_q <= '{addr:  req_addr_i,
                   wdata: req_wdata_i,
                   size:  req_size_i,
                   we:    req_we_i,
                   uns:   req_unsigned_i,
                   err:   bad_req};
      end
      if (state_q == S_RD || state_q == S_RMW_RD) begin
        cap_q <= mem_data_i;
      end
    end
  end

  assign mem_addr_o = req_q.addr;

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    mem_data_o   = '0;
    mem_signal_o = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (bad_req)                     state_d = S_RESP;
          else if (!req_we_i)              state_d = S_RD;
          else if (req_size_i == SZ_WORD)  state_d = S_WR;
          else                             state_d = S_RMW_RD;
        end
      end
      S_RD, S_RMW_RD: begin
        mem_signal_o[MEM_SIG_RD] = 1'b1;
        state_d = (state_q == S_RD) ? S_RESP : S_WR;
      end
      S_WR: begin
        mem_signal_o[MEM_SIG_WR] = 1'b1;
        mem_data_o = wword;
        state_d    = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = req_q.err;
        resp_rdata_o = (req_q.err || req_q.we) ? '0 : rdata;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array memory and a
// per-cycle reference model of the expected port activity.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 32;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [2:0]  mem_signal_o;
  logic [31:0] mem_data_i;

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // observations of the DUT, for literal checks in the directed tests
  int resp_cnt = 0, acc_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  int last_lat = 0, last_wr_off = 0;
  logic [31:0] last_rdata = '0, last_wr_data = '0, last_wr_addr = '0;
  logic        last_err = 1'b0;

  // outstanding-request model
  logic        o_act = 1'b0;
  int          o_t0 = 0, o_lat = 0, o_rd_cyc = -1, o_wr_cyc = -1;
  logic        o_err = 1'b0;
  logic [31:0] o_addr = '0, o_wword = '0, o_rdata = '0;
  logic [7:0]  o_nb [4];

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_signal_o   (mem_signal_o),
    .mem_data_i     (mem_data_i)
  );

  always_comb begin
    mem_data_i = '0;
    for (int k = 0; k < 4; k++)
      if (longint'(mem_addr_o) + k < MEM_BYTES)
        mem_data_i[8*k +: 8] = mem[mem_addr_o + 32'(k)];
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_signal_o[0])
      for (int k = 0; k < 4; k++)
        if (longint'(mem_addr_o) + k < MEM_BYTES)
          mem[mem_addr_o + 32'(k)] <= mem_data_o[8*k +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[a + 32'(k)];
    return w;
  endfunction

  // compare process: checks every cycle against the model
  initial begin
    logic [2:0] exp_sig;
    logic       exp_resp, was_act;
    int         n;
    logic [31:0] w, v;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      was_act = o_act;
      exp_sig = 3'b000;
      if (o_act && o_rd_cyc == cyc) exp_sig = 3'b010;
      if (o_act && o_wr_cyc == cyc) exp_sig = 3'b001;
      exp_resp = o_act && (cyc == o_t0 + o_lat);
      chk("mem_signal", 32'(mem_signal_o), 32'(exp_sig));
      chk("req_ready", 32'(req_ready_o), 32'(!o_act));
      chk("mem_data", mem_data_o, (exp_sig == 3'b001) ? o_wword : 32'h0);
      if (exp_sig != 3'b000) chk("mem_addr", mem_addr_o, o_addr);
      chk("resp_valid", 32'(resp_valid_o), 32'(exp_resp));
      chk("resp_rdata", resp_rdata_o, exp_resp ? o_rdata : 32'h0);
      chk("resp_err", 32'(resp_err_o), 32'(exp_resp && o_err));
      if (mem_signal_o[1]) rd_cnt++;
      if (mem_signal_o[0]) begin
        wr_cnt++;
        last_wr_data = mem_data_o;
        last_wr_addr = mem_addr_o;
        last_wr_off  = cyc - o_t0;
      end
      if (exp_sig == 3'b001)
        for (int k = 0; k < 4; k++) ref_mem[o_addr + 32'(k)] = o_nb[k];
      if (resp_valid_o) begin
        resp_cnt++;
        last_rdata = resp_rdata_o;
        last_err   = resp_err_o;
        last_lat   = cyc - o_t0;
      end
      if (exp_resp) o_act = 1'b0;
      if (!rst_n_i) begin
        o_act = 1'b0;
      end else if (req_valid_i && !was_act) begin
        acc_cnt++;
        o_act    = 1'b1;
        o_t0     = cyc;
        o_addr   = req_addr_i;
        o_err    = (req_size_i == 2'd3) ||
                   (longint'(req_addr_i) + 3 >= MEM_BYTES);
        o_rd_cyc = -1;
        o_wr_cyc = -1;
        o_rdata  = '0;
        o_wword  = '0;
        if (o_err) begin
          o_lat = 1;
        end else if (!req_we_i) begin
          o_lat    = 2;
          o_rd_cyc = cyc + 1;
          w = ref_word(req_addr_i);
          if (req_size_i == 2'd0) begin
            v = w & 32'hFF;
            if (!req_unsigned_i && v >= 32'h80) v = v + 32'hFFFFFF00;
          end else if (req_size_i == 2'd1) begin
            v = w & 32'hFFFF;
            if (!req_unsigned_i && v >= 32'h8000) v = v + 32'hFFFF0000;
          end else begin
            v = w;
          end
          o_rdata = v;
        end else begin
          n = (req_size_i == 2'd0) ? 1 : (req_size_i == 2'd1) ? 2 : 4;
          o_lat    = (n == 4) ? 2 : 3;
          o_rd_cyc = (n == 4) ? -1 : cyc + 1;
          o_wr_cyc = cyc + o_lat - 1;
          for (int k = 0; k < 4; k++) begin
            o_nb[k] = (k < n) ? req_wdata_i[8*k +: 8]
                              : ref_mem[req_addr_i + 32'(k)];
            o_wword[8*k +: 8] = o_nb[k];
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
    int n, start;
    start = resp_cnt;
    @(posedge clk_i); #1;
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = a;
    req_wdata_i    = wd;
    n = 0;
    while (!req_ready_o && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 10) chk("accept_timeout", 32'(n), 32'(0));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (resp_cnt == start && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    if (resp_cnt == start) chk("resp_timeout", 32'(n), 32'(0));
  endtask

  initial begin
    int rc, wc, ac, rdc, n;
    logic [7:0] saved [4];
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[i]     = 8'(i * 13 + 5);
      ref_mem[i] = 8'(i * 13 + 5);
    end
    mem[8] = 8'h44; mem[9] = 8'h33; mem[10] = 8'h22; mem[11] = 8'h11;
    ref_mem[8] = 8'h44; ref_mem[9] = 8'h33;
    ref_mem[10] = 8'h22; ref_mem[11] = 8'h11;
    mem[0] = 8'h80; mem[1] = 8'hFF;
    ref_mem[0] = 8'h80; ref_mem[1] = 8'hFF;

    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_mem_signal", 32'(mem_signal_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);

    do_req(1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF);
    chk("wst_lat", 32'(last_lat), 32'd2);
    chk("wst_wr_off", 32'(last_wr_off), 32'd1);
    chk("wst_wr_addr", last_wr_addr, 32'd4);
    chk("wst_wr_data", last_wr_data, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'd4, 32'h0);
    chk("wld_data", last_rdata, 32'hDEADBEEF);
    chk("wld_lat", 32'(last_lat), 32'd2);

    do_req(1'b1, 2'd0, 1'b0, 32'd8, 32'h123456AA);
    chk("bst_wr_off", 32'(last_wr_off), 32'd2);
    chk("bst_wr_data", last_wr_data, 32'h112233AA);
    chk("bst_lat", 32'(last_lat), 32'd3);
    do_req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    chk("bst_readback", last_rdata, 32'h112233AA);

    do_req(1'b0, 2'd0, 1'b0, 32'd0, 32'h0);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'd0, 32'h0);
    chk("lb_unsigned", last_rdata, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'd0, 32'h0);
    chk("lh_signed", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd1, 1'b1, 32'd0, 32'h0);
    chk("lh_unsigned", last_rdata, 32'h0000FF80);

    do_req(1'b1, 2'd1, 1'b0, 32'd13, 32'hCAFE1234);
    chk("hst_wr_off", 32'(last_wr_off), 32'd2);
    do_req(1'b0, 2'd2, 1'b0, 32'd12, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'd28, 32'hA5A55A5A);
    do_req(1'b0, 2'd2, 1'b0, 32'd28, 32'h0);
    chk("edge_word", last_rdata, 32'hA5A55A5A);

    rdc = rd_cnt; wc = wr_cnt;
    do_req(1'b0, 2'd2, 1'b0, 32'd29, 32'h0);
    chk("err_range", 32'(last_err), 32'd1);
    chk("err_lat", 32'(last_lat), 32'd1);
    chk("err_rdata", last_rdata, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'd0, 32'h0);
    chk("err_size", 32'(last_err), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
    chk("err_wrap", 32'(last_err), 32'd1);
    do_req(1'b1, 2'd0, 1'b0, 32'd31, 32'h77);
    chk("err_store", 32'(last_err), 32'd1);
    chk("err_no_rd", 32'(rd_cnt), 32'(rdc));
    chk("err_no_wr", 32'(wr_cnt), 32'(wc));

    rc = resp_cnt; ac = acc_cnt;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
    req_unsigned_i = 1'b0; req_addr_i = 32'd8;
    n = 0;
    while (acc_cnt < ac + 3 && n < 30) begin
      @(posedge clk_i); #1; n++;
    end
    req_valid_i = 1'b0;
    chk("b2b_cycles", 32'(n), 32'd7);
    n = 0;
    while (resp_cnt < rc + 3 && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    chk("b2b_resps", 32'(resp_cnt - rc), 32'd3);
    chk("b2b_accepts", 32'(acc_cnt - ac), 32'd3);

    for (int k = 0; k < 4; k++) saved[k] = mem[12 + k];
    rc = resp_cnt; wc = wr_cnt;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd0;
    req_addr_i = 32'd12; req_wdata_i = 32'h55;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    chk("rst_mid_rmw_rd", 32'(mem_signal_o), 32'h2);
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    chk("rst_mid_idle", 32'(req_ready_o), 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
    chk("rst_mid_no_wr", 32'(wr_cnt), 32'(wc));
    chk("rst_mid_no_resp", 32'(resp_cnt), 32'(rc));
    for (int k = 0; k < 4; k++)
      chk("rst_mid_mem", 32'(mem[12 + k]), 32'(saved[k]));

    do_req(1'b0, 2'd2, 1'b0, 32'd12, 32'h0);
    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
